// File: rtl/kmeans_addsub_arbiter.sv
// kmeans_addsub_arbiter: round-robin share of one 32-bit ripple add/sub.
// Define KM_ADDSUB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module kmeans_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
`ifdef KM_ADDSUB_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic [ID_W-1:0]       rsp_id
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               found;
  logic               accept, rs_load, os_free;

  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               op_q, op_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               os_valid_q, os_valid_d;

  logic [31:0]        sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [ID_W-1:0]    rid_q, rid_d;
  logic               rvalid_q, rvalid_d;
  logic               ovf_d;

  logic [31:0]        dp_s, dp_co;

  // Round-robin search: first valid requester at or after ptr wins.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    idx    = 0;
    sel    = '0;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && req_valid[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        gnt_id     = sel;
      end
    end
  end

  assign rs_load   = os_valid_q & (~rvalid_q | rsp_ready);
  assign os_free   = ~os_valid_q | rs_load;
  assign accept    = found & os_free;
  assign req_ready = grant & {NUM_REQ{os_free}};

  // Ripple add/sub; b inverted and carry-in set for two's complement subtract.
  always_comb begin
    logic c;
    logic bx;
    c     = op_q;
    bx    = 1'b0;
    dp_s  = '0;
    dp_co = '0;
    for (int i = 0; i < 32; i++) begin
      bx       = b_q[i] ^ op_q;
      dp_s[i]  = a_q[i] ^ bx ^ c;
      dp_co[i] = (a_q[i] & bx) | (c & (a_q[i] ^ bx));
      c        = dp_co[i];
    end
  end

  // Next state for pointer, operand stage and result stage.
  always_comb begin
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    os_valid_d = os_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    rid_d      = rid_q;
    rvalid_d   = rvalid_q;
    ovf_d      = dp_co[30] ^ dp_co[31];
    if (accept) begin
      a_d        = req_a[32*int'(gnt_id) +: 32];
      b_d        = req_b[32*int'(gnt_id) +: 32];
      op_d       = req_op[gnt_id];
      id_d       = gnt_id;
      os_valid_d = 1'b1;
      if (gnt_id == ID_W'(NUM_REQ-1)) ptr_d = '0;
      else ptr_d = gnt_id + ID_W'(1);
    end else if (rs_load) begin
      os_valid_d = 1'b0;
    end
    if (rs_load) begin
      sum_d    = dp_s;
      cout_d   = dp_co[31];
      rid_d    = id_q;
      rvalid_d = 1'b1;
    end else if (rvalid_q && rsp_ready) begin
      rvalid_d = 1'b0;
    end
  end

  // Arbiter pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Operand stage in front of the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      id_q       <= '0;
      os_valid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      id_q       <= id_d;
      os_valid_q <= os_valid_d;
    end
  end

  // Result stage driving the shared response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      cout_q   <= 1'b0;
      rid_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      rid_q    <= rid_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef KM_ADDSUB_OVF_EN
  logic ovf_q;

  // Signed overflow travels with the result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (rs_load) ovf_q <= ovf_d;
  end

  assign rsp_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

  assign rsp_valid = rvalid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = rid_q;

endmodule

// File: tb/tb_kmeans_addsub_arbiter.sv
// tb_kmeans_addsub_arbiter: directed checks of arbitration, datapath and flow.
// Overflow checks are included when KM_ADDSUB_OVF_EN is defined.
module tb_kmeans_addsub_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]  req_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_sum;
  logic          rsp_cout;
  logic [1:0]    rsp_id;
`ifdef KM_ADDSUB_OVF_EN
  logic          rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  kmeans_addsub_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout),
`ifdef KM_ADDSUB_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic op);
    req_valid[i]       = 1'b1;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_op[i]          = op;
  endtask

  task automatic do_one(input string tag, input int i,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] es,
                        input logic ec, input logic eo);
    set_req(i, a, b, op);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << i);
    tick();
    req_valid[i] = 1'b0;
    chk({tag, "_lat1"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_sum"}, rsp_sum, es);
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
    chk({tag, "_id"}, 32'(rsp_id), 32'(i));
`ifdef KM_ADDSUB_OVF_EN
    chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x overflow flag");
`endif
    tick();
    chk({tag, "_drain"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int ord [5];
    logic [31:0] rr_sum [N];
    logic [31:0] bp_sum [N];
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) rr_sum[i] = 32'(100 * (i + 1) + i);
    bp_sum[0] = 32'd1000;
    bp_sum[1] = 32'd998;
    bp_sum[2] = 32'd1008;
    bp_sum[3] = 32'd994;

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sum", rsp_sum, 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    do_one("add", 0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0);
    do_one("sub_neg", 2, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_one("sub_pos", 2, 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0);
    do_one("wrap", 0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    do_one("ovf", 3, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) set_req(i, 32'(100 * (i + 1)), 32'(i), 1'b0);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", 32'(req_ready), 32'(1) << ord[k]);
      tick();
      if (k > 0) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_id), 32'(ord[k-1]));
        chk("rr_sum", rsp_sum, rr_sum[ord[k-1]]);
      end
    end
    req_valid = '0;
    tick();
    chk("rr_last_valid", 32'(rsp_valid), 32'd1);
    chk("rr_last_id", 32'(rsp_id), 32'd0);
    chk("rr_last_sum", rsp_sum, rr_sum[0]);
    tick();
    chk("rr_idle", 32'(rsp_valid), 32'd0);

    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++)
      set_req(i, 32'(1000 + i), 32'(3 * i), 1'(i % 2));
    #1;
    chk("bp_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    chk("bp_empty", 32'(rsp_valid), 32'd0);
    chk("bp_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      chk("bp_stall_valid", 32'(rsp_valid), 32'd1);
      chk("bp_stall_id", 32'(rsp_id), 32'd1);
      chk("bp_stall_sum", rsp_sum, bp_sum[1]);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    chk("bp_d2_id", 32'(rsp_id), 32'd2);
    chk("bp_d2_sum", rsp_sum, bp_sum[2]);
    chk("bp_ready0", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    chk("bp_d3_id", 32'(rsp_id), 32'd3);
    chk("bp_d3_sum", rsp_sum, bp_sum[3]);
    tick();
    chk("bp_d0_valid", 32'(rsp_valid), 32'd1);
    chk("bp_d0_id", 32'(rsp_id), 32'd0);
    chk("bp_d0_sum", rsp_sum, bp_sum[0]);
    tick();
    chk("bp_done", 32'(rsp_valid), 32'd0);

    set_req(1, 32'd9, 32'd9, 1'b0);
    #1;
    chk("mr_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    rsp_ready = 1'b0;
    tick();
    chk("mr_valid", 32'(rsp_valid), 32'd1);
    chk("mr_sum", rsp_sum, 32'd18);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(rsp_valid), 32'd0);
    chk("mr_async_sum", rsp_sum, 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("mr_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    chk("mr_no_stale2", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    set_req(0, 32'd20, 32'd1, 1'b0);
    set_req(1, 32'd9, 32'd9, 1'b0);
    #1;
    chk("mr_prio", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("mr_lat", 32'(rsp_valid), 32'd0);
    tick();
    chk("mr_res_valid", 32'(rsp_valid), 32'd1);
    chk("mr_res_id", 32'(rsp_id), 32'd0);
    chk("mr_res_sum", rsp_sum, 32'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
